// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter
//   Shares one single-ported 64-bit data memory between the fetch requester
//   (f_*) and the memory stage (d_*). Only one transaction is in flight at a
//   time. Each accepted request is answered with exactly one response pulse.
//   The data port has priority over fetch. A starvation counter forces a fetch
//   grant after STARVE_MAX consecutive data grants that found fetch waiting.
//   A request to a word address at or beyond MEM_DEPTH is answered with err=1
//   and never reaches the memory.
// Ports
//   clk, rst_n                      clock; asynchronous active-low reset
//   f_req_valid/f_addr/f_req_ready  fetch read request handshake
//   f_rsp_valid/f_rsp_data/f_rsp_err  fetch response (1-cycle pulse)
//   d_req_valid/d_req_we/d_addr/d_wdata/d_req_ready  data request handshake
//   d_rsp_valid/d_rsp_data/d_rsp_err  data response (1-cycle pulse)
//   m_en/m_we/m_addr/m_wdata/m_rdata  memory port; m_rdata is valid MEM_LAT
//                                     cycles after the m_en cycle
//   busy                            high whenever the FSM is not idle
module y86_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int MEM_DEPTH  = 1024,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SW-1:0]     r_starve;
  logic              r_owner_d;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CW-1:0]     r_cnt;

  logic              w_idle;
  logic              w_f_win;
  logic              w_f_acc;
  logic              w_d_acc;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_oor;

  // ready is gated by rst_n so every output reads 0 while reset is held,
  // even if a requester is already presenting valid.
  assign w_idle     = rst_n & (r_state == S_IDLE);
  assign w_f_win    = f_req_valid & (~d_req_valid | (r_starve == SW'(STARVE_MAX)));
  assign w_f_acc    = w_idle & w_f_win;
  assign w_d_acc    = w_idle & d_req_valid & ~w_f_win;
  assign w_accept   = w_f_acc | w_d_acc;
  assign w_sel_addr = w_d_acc ? d_addr : f_addr;
  assign w_oor      = {1'b0, w_sel_addr} >= LP_DEPTH;

  assign f_req_ready = w_f_acc;
  assign d_req_ready = w_d_acc;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    f_rsp_valid = 1'b0;
    f_rsp_data  = '0;
    f_rsp_err   = 1'b0;
    d_rsp_valid = 1'b0;
    d_rsp_data  = '0;
    d_rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_oor ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        m_en    = 1'b1;
        m_we    = r_we;
        m_addr  = r_addr;
        m_wdata = r_wdata;
        w_next  = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_RESP;
      end
      S_RESP: begin
        if (r_owner_d) begin
          d_rsp_valid = 1'b1;
          d_rsp_data  = r_rdata;
          d_rsp_err   = r_err;
        end else begin
          f_rsp_valid = 1'b1;
          f_rsp_data  = r_rdata;
          f_rsp_err   = r_err;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_rdata is cleared on accept so writes and errors respond with 0 data;
  // only a read's final WAIT cycle loads it from memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_owner_d <= w_d_acc;
        r_we      <= w_d_acc & d_req_we;
        r_wdata   <= w_d_acc ? d_wdata : '0;
        r_addr    <= w_sel_addr;
        r_err     <= w_oor;
        r_rdata   <= '0;
      end
      if (r_state == S_ACCESS) r_cnt <= CW'(MEM_LAT - 1);
      if (r_state == S_WAIT) begin
        if (r_cnt == '0) r_rdata <= m_rdata;
        else             r_cnt   <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_f_acc) begin
      r_starve <= '0;
    end else if (w_d_acc && f_req_valid && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
module tb_y86_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rsp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rsp_data;
  logic          m_en, m_we, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  // memory model: 2-cycle read latency, preload port for initial contents
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] pipe0 = '0, pipe1 = '0;
  logic          pl_en;
  logic [9:0]    pl_addr;
  logic [DW-1:0] pl_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (m_en && m_we) mem[m_addr[9:0]] <= m_wdata;
    pipe0 <= (m_en && !m_we) ? mem[m_addr[9:0]] : '0;
    pipe1 <= pipe0;
  end
  assign m_rdata = pipe1;

  y86_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_addr(f_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    f_req_valid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (f_req_ready !== 1'b0) begin errors++; $display("FAIL rst_f_ready got %0b exp 0", f_req_ready); end
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en got %0b exp 0", m_en); end
    checks++; if (f_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp got f%0b d%0b exp 0 0", f_rsp_valid, d_rsp_valid); end
    checks++; if (m_addr !== '0) begin errors++; $display("FAIL rst_m_addr got %h exp 0", m_addr); end
    f_req_valid = 1'b0;
  endtask

  // fetch read of address 5 (preloaded 0xDEAD); response at T+4
  task automatic test_fetch_read(input string tag);
    f_addr = 16'd5; f_req_valid = 1'b1;
    #1;
    checks++; if (f_req_ready !== 1'b1) begin errors++; $display("FAIL %s_f_ready got %0b exp 1", tag, f_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL %s_d_ready got %0b exp 0", tag, d_req_ready); end
    step; f_req_valid = 1'b0;                                  // T+1
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0) begin errors++; $display("FAIL %s_m_en got en%0b we%0b exp en1 we0", tag, m_en, m_we); end
    checks++; if (m_addr !== 16'd5) begin errors++; $display("FAIL %s_m_addr got %0d exp 5", tag, m_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy1 got %0b exp 1", tag, busy); end
    step;                                                      // T+2
    checks++; if (m_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_t2 got en%0b busy%0b exp en0 busy1", tag, m_en, busy); end
    step;                                                      // T+3
    checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_early_rsp got %0b exp 0", tag, f_rsp_valid); end
    step;                                                      // T+4
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_rsp_valid got %0b exp 1", tag, f_rsp_valid); end
    checks++; if (f_rsp_data !== 64'hDEAD || f_rsp_err !== 1'b0) begin errors++; $display("FAIL %s_rsp_data got %h err%0b exp dead err0", tag, f_rsp_data, f_rsp_err); end
    checks++; if (d_rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_t4 got d%0b busy%0b exp d0 busy1", tag, d_rsp_valid, busy); end
    step;                                                      // T+5
    checks++; if (busy !== 1'b0 || f_rsp_valid !== 1'b0 || f_rsp_data !== '0) begin errors++; $display("FAIL %s_idle got busy%0b v%0b data %h exp 0 0 0", tag, busy, f_rsp_valid, f_rsp_data); end
  endtask

  task automatic test_data_write_read;
    d_addr = 16'd7; d_wdata = 64'h1234; d_req_we = 1'b1; d_req_valid = 1'b1;
    #1;
    checks++; if (d_req_ready !== 1'b1 || f_req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready got d%0b f%0b exp d1 f0", d_req_ready, f_req_ready); end
    step; d_req_valid = 1'b0;                                  // T+1
    checks++; if (m_en !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL wr_m_en got en%0b we%0b exp 1 1", m_en, m_we); end
    checks++; if (m_addr !== 16'd7 || m_wdata !== 64'h1234) begin errors++; $display("FAIL wr_m_bus got %0d %h exp 7 1234", m_addr, m_wdata); end
    checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_early_rsp got %0b exp 0", d_rsp_valid); end
    step;                                                      // T+2
    checks++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== '0 || d_rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp got v%0b %h e%0b exp 1 0 0", d_rsp_valid, d_rsp_data, d_rsp_err); end
    step;                                                      // T+3
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle got %0b exp 0", busy); end
    d_req_we = 1'b0; d_req_valid = 1'b1;
    #1;
    step; d_req_valid = 1'b0;
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0) begin errors++; $display("FAIL rd7_m_en got en%0b we%0b exp 1 0", m_en, m_we); end
    step; step; step;
    checks++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 64'h1234) begin errors++; $display("FAIL rd7_rsp got v%0b %h exp 1 1234", d_rsp_valid, d_rsp_data); end
    checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd7_f_rsp got %0b exp 0", f_rsp_valid); end
    step;
  endtask

  task automatic test_priority;
    f_addr = 16'd5; f_req_valid = 1'b1;
    d_addr = 16'd3; d_wdata = 64'h77; d_req_we = 1'b1; d_req_valid = 1'b1;
    #1;
    checks++; if (d_req_ready !== 1'b1 || f_req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got d%0b f%0b exp d1 f0", d_req_ready, f_req_ready); end
    step; d_req_valid = 1'b0; #1;                              // T+1
    checks++; if (f_req_ready !== 1'b0) begin errors++; $display("FAIL prio_busy_f_ready got %0b exp 0", f_req_ready); end
    step;                                                      // T+2
    checks++; if (d_rsp_valid !== 1'b1 || f_req_ready !== 1'b0) begin errors++; $display("FAIL prio_d_rsp got v%0b fr%0b exp 1 0", d_rsp_valid, f_req_ready); end
    step;                                                      // T+3 idle
    checks++; if (f_req_ready !== 1'b1) begin errors++; $display("FAIL prio_f_accept got %0b exp 1", f_req_ready); end
    step; f_req_valid = 1'b0;
    step; step; step;
    checks++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 64'hDEAD || d_rsp_valid !== 1'b0) begin errors++; $display("FAIL prio_f_rsp got v%0b %h d%0b exp 1 dead 0", f_rsp_valid, f_rsp_data, d_rsp_valid); end
    step;
  endtask

  task automatic test_starvation;
    logic [9:0] exp_f;
    int n;
    exp_f = 10'b10000_10000;   // grants 0..9: d,d,d,d,f,d,d,d,d,f
    n = 0;
    f_addr = 16'd5; f_req_valid = 1'b1;
    d_addr = 16'd8; d_wdata = 64'h55; d_req_we = 1'b1; d_req_valid = 1'b1;
    for (int c = 0; c < 200 && n < 10; c++) begin
      #1;
      if (f_req_ready || d_req_ready) begin
        checks++; if (f_req_ready !== exp_f[n] || d_req_ready !== !exp_f[n]) begin errors++; $display("FAIL starve_grant%0d got f%0b d%0b exp f%0b", n, f_req_ready, d_req_ready, exp_f[n]); end
        n++;
      end
      step;
    end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL starve_timeout got %0d grants exp 10", n); end
    for (int c = 0; c < 20 && busy; c++) step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_drain got busy %0b exp 0", busy); end
  endtask

  task automatic test_error;
    d_addr = 16'd1024; d_req_we = 1'b0; d_req_valid = 1'b1;
    #1;
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %0b exp 1", d_req_ready); end
    step; d_req_valid = 1'b0;                                  // T+1
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL err_m_en got %0b exp 0", m_en); end
    checks++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_data !== '0) begin errors++; $display("FAIL err_rsp got v%0b e%0b %h exp 1 1 0", d_rsp_valid, d_rsp_err, d_rsp_data); end
    step;
    checks++; if (busy !== 1'b0 || d_rsp_valid !== 1'b0 || d_rsp_err !== 1'b0) begin errors++; $display("FAIL err_idle got b%0b v%0b e%0b exp 0 0 0", busy, d_rsp_valid, d_rsp_err); end
    // last valid word
    d_addr = 16'd1023; d_wdata = 64'hAB; d_req_we = 1'b1; d_req_valid = 1'b1;
    #1;
    step; d_req_valid = 1'b0;
    checks++; if (m_en !== 1'b1 || m_addr !== 16'd1023) begin errors++; $display("FAIL edge_m_en got en%0b %0d exp 1 1023", m_en, m_addr); end
    step;
    checks++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0) begin errors++; $display("FAIL edge_rsp got v%0b e%0b exp 1 0", d_rsp_valid, d_rsp_err); end
    step;
    // fetch out of range
    f_addr = 16'hFFFF; f_req_valid = 1'b1;
    #1;
    step; f_req_valid = 1'b0;
    checks++; if (m_en !== 1'b0 || f_rsp_valid !== 1'b1 || f_rsp_err !== 1'b1 || f_rsp_data !== '0) begin errors++; $display("FAIL ferr_rsp got en%0b v%0b e%0b %h exp 0 1 1 0", m_en, f_rsp_valid, f_rsp_err, f_rsp_data); end
    step;
  endtask

  task automatic test_reset_midflight;
    int pulses;
    pulses = 0;
    f_addr = 16'd5; f_req_valid = 1'b1;
    #1;
    step; f_req_valid = 1'b0;                                  // ACCESS
    step;                                                      // WAIT
    #2; rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || m_en !== 1'b0 || f_rsp_valid !== 1'b0 || f_req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got b%0b en%0b v%0b r%0b exp 0 0 0 0", busy, m_en, f_rsp_valid, f_req_ready); end
    step; step;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step;
      if (f_rsp_valid || d_rsp_valid) pulses++;
    end
    checks++; if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got %0d pulses busy%0b exp 0 0", pulses, busy); end
    test_fetch_read("t6");
  endtask

  initial begin
    rst_n = 1'b0;
    f_req_valid = 1'b0; f_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_addr = '0; d_wdata = '0;
    pl_en = 1'b1; pl_addr = 10'd5; pl_data = 64'hDEAD;
    @(posedge clk); #1; pl_en = 1'b0;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    step;
    test_fetch_read("t1");
    test_data_write_read;
    test_priority;
    test_starvation;
    test_error;
    test_reset_midflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
